// File: rtl/program_dispatcher_pkg.sv
// Shared types and helpers for the runtime program dispatcher.
package program_dispatcher_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_VS  = 2'd1,
    HOLD_RST = 2'd2
  } dispatch_state_t;

  localparam bit SYNC_ACTIVE_LOW = 1'b0;

  // Width of a counter that must be able to hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/program_dispatcher_if.sv
// Selector, per-program video/LED slices and the selected outputs bundled as one bus.
interface program_dispatcher_if #(
  parameter int unsigned NUM_PROGS = 4,
  parameter int unsigned RGB_W     = 4,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SEL_W     = $clog2(NUM_PROGS)
);
  logic [SEL_W-1:0]           sel_in;
  logic [NUM_PROGS*RGB_W-1:0] prog_r_in;
  logic [NUM_PROGS*RGB_W-1:0] prog_g_in;
  logic [NUM_PROGS*RGB_W-1:0] prog_b_in;
  logic [NUM_PROGS-1:0]       prog_hs_in;
  logic [NUM_PROGS-1:0]       prog_vs_in;
  logic [NUM_PROGS*LED_W-1:0] prog_led_in;
  logic [NUM_PROGS-1:0]       prog_rst_out;
  logic [RGB_W-1:0]           vga_r_out;
  logic [RGB_W-1:0]           vga_g_out;
  logic [RGB_W-1:0]           vga_b_out;
  logic                       vga_hs_out;
  logic                       vga_vs_out;
  logic [LED_W-1:0]           led_out;
  logic [SEL_W-1:0]           active_sel_out;
  logic                       switching_out;

  modport master (
    output sel_in, prog_r_in, prog_g_in, prog_b_in, prog_hs_in, prog_vs_in, prog_led_in,
    input  prog_rst_out, vga_r_out, vga_g_out, vga_b_out, vga_hs_out, vga_vs_out,
           led_out, active_sel_out, switching_out
  );

  modport slave (
    input  sel_in, prog_r_in, prog_g_in, prog_b_in, prog_hs_in, prog_vs_in, prog_led_in,
    output prog_rst_out, vga_r_out, vga_g_out, vga_b_out, vga_hs_out, vga_vs_out,
           led_out, active_sel_out, switching_out
  );
endinterface

// File: rtl/program_dispatcher_sel_debouncer.sv
// Synchronises the raw switch selector and accepts a value only after it has been
// seen unchanged for STABLE_CYCLES consecutive samples.
module program_dispatcher_sel_debouncer
  import program_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sel_raw,
  output logic [WIDTH-1:0] sel_stable,
  output logic             sel_valid
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of consecutive samples equal to cand, saturating at the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      cnt        <= '0;
      sel_stable <= '0;
      sel_valid  <= 1'b0;
    end else begin
      sync1     <= sel_raw;
      sync2     <= sync1;
      sel_valid <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CNT_W'(1);
      end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end else if (cand != sel_stable) begin
        sel_stable <= cand;
        sel_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_dispatcher.sv
// Runtime program selector: switches the VGA/LED outputs between NUM_PROGS programs at a
// frame boundary, holding the newly selected program in reset before exposing it.
module program_dispatcher
  import program_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PROGS      = 4,
  parameter int unsigned SEL_W          = $clog2(NUM_PROGS),
  parameter int unsigned RGB_W          = 4,
  parameter int unsigned LED_W          = 16,
  parameter bit          SYNC_POL       = SYNC_ACTIVE_LOW,
  parameter int unsigned STABLE_CYCLES  = 1_000_000,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input logic                 clk_in,
  input logic                 rst_in,
  program_dispatcher_if.slave bus
);

  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned RC_W = cnt_width(RESET_CYCLES);

  dispatch_state_t state, state_next;
  logic [SEL_W-1:0] sel_stable;
  logic             sel_valid;
  logic             sel_ok;
  logic [SEL_W-1:0] target, target_next;
  logic [SEL_W-1:0] active, active_next;
  logic [TO_W-1:0]  wait_cnt;
  logic [RC_W-1:0]  rst_cnt;
  logic             vs_now, vs_prev, vs_edge;
  logic             timeout, rst_done;

  logic [NUM_PROGS-1:0] rst_d;
  logic [RGB_W-1:0]     r_d, g_d, b_d;
  logic                 hs_d, vs_d;
  logic [LED_W-1:0]     led_d;

  logic [NUM_PROGS-1:0] rst_q;
  logic [RGB_W-1:0]     r_q, g_q, b_q;
  logic                 hs_q, vs_q;
  logic [LED_W-1:0]     led_q;
  logic                 switching_q;

  program_dispatcher_sel_debouncer #(
    .WIDTH        (SEL_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debouncer (
    .clk       (clk_in),
    .rst       (rst_in),
    .sel_raw   (bus.sel_in),
    .sel_stable(sel_stable),
    .sel_valid (sel_valid)
  );

  assign sel_ok   = {1'b0, sel_stable} < (SEL_W + 1)'(NUM_PROGS);
  assign timeout  = wait_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign rst_done = rst_cnt == RC_W'(RESET_CYCLES - 1);
  assign vs_edge  = (vs_now == SYNC_POL) && (vs_prev != SYNC_POL);

  always_comb begin : vs_select
    vs_now = ~SYNC_POL;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (active == SEL_W'(i)) vs_now = bus.prog_vs_in[i];
    end
  end

  always_ff @(posedge clk_in) begin : state_reg
    if (rst_in) state <= HOLD_RST;
    else        state <= state_next;
  end

  // A request back to the running program cancels the switch before any frame-edge exit.
  always_comb begin : next_state
    state_next  = state;
    target_next = target;
    case (state)
      RUN: begin
        if (sel_ok && (sel_stable != active)) begin
          state_next  = WAIT_VS;
          target_next = sel_stable;
        end
      end
      WAIT_VS: begin
        if (sel_valid && sel_ok && (sel_stable == active)) begin
          state_next = RUN;
        end else begin
          if (sel_valid && sel_ok) target_next = sel_stable;
          if (vs_edge || timeout)  state_next  = HOLD_RST;
        end
      end
      HOLD_RST: begin
        if (rst_done) state_next = RUN;
      end
      default: state_next = HOLD_RST;
    endcase
  end

  assign active_next = ((state != HOLD_RST) && (state_next == HOLD_RST)) ? target_next : active;

  // Counters restart on every state entry.
  always_ff @(posedge clk_in) begin : datapath_reg
    if (rst_in) begin
      target   <= '0;
      active   <= '0;
      wait_cnt <= '0;
      rst_cnt  <= '0;
      vs_prev  <= ~SYNC_POL;
    end else begin
      target   <= target_next;
      active   <= active_next;
      wait_cnt <= ((state == WAIT_VS) && (state_next == WAIT_VS)) ? wait_cnt + 1'b1 : '0;
      rst_cnt  <= ((state == HOLD_RST) && (state_next == HOLD_RST)) ? rst_cnt + 1'b1 : '0;
      vs_prev  <= vs_now;
    end
  end

  // Output values for the coming cycle; blanked whenever the active program is in reset.
  always_comb begin : output_decode
    rst_d = '1;
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    hs_d  = ~SYNC_POL;
    vs_d  = ~SYNC_POL;
    led_d = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if ((active_next == SEL_W'(i)) && (state_next != HOLD_RST)) begin
        rst_d[i] = 1'b0;
        r_d      = bus.prog_r_in[i*RGB_W +: RGB_W];
        g_d      = bus.prog_g_in[i*RGB_W +: RGB_W];
        b_d      = bus.prog_b_in[i*RGB_W +: RGB_W];
        hs_d     = bus.prog_hs_in[i];
        vs_d     = bus.prog_vs_in[i];
        led_d    = bus.prog_led_in[i*LED_W +: LED_W];
      end
    end
  end

  always_ff @(posedge clk_in) begin : output_reg
    if (rst_in) begin
      rst_q       <= '1;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      led_q       <= '0;
      switching_q <= 1'b1;
    end else begin
      rst_q       <= rst_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      led_q       <= led_d;
      switching_q <= state_next != RUN;
    end
  end

  assign bus.prog_rst_out   = rst_q;
  assign bus.vga_r_out      = r_q;
  assign bus.vga_g_out      = g_q;
  assign bus.vga_b_out      = b_q;
  assign bus.vga_hs_out     = hs_q;
  assign bus.vga_vs_out     = vs_q;
  assign bus.led_out        = led_q;
  assign bus.active_sel_out = active;
  assign bus.switching_out  = switching_q;

endmodule

// File: tb/tb_program_dispatcher.sv
// Directed bench for program_dispatcher: reset sequence, frame-aligned switching,
// glitch rejection, vsync timeout, cancel/retarget and reset during a switch.
module tb_program_dispatcher;

  localparam int unsigned NUM_PROGS = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned RGB_W     = 4;
  localparam int unsigned LED_W     = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  program_dispatcher_if #(
    .NUM_PROGS(NUM_PROGS), .RGB_W(RGB_W), .LED_W(LED_W), .SEL_W(SEL_W)
  ) bus ();

  program_dispatcher #(
    .NUM_PROGS(NUM_PROGS), .SEL_W(SEL_W), .RGB_W(RGB_W), .LED_W(LED_W),
    .SYNC_POL(1'b0), .STABLE_CYCLES(4), .RESET_CYCLES(3), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for switching_out to reach lvl; an expired bound shows up as a failed check.
  task automatic wait_switch(input string tag, input logic lvl, input int limit);
    int n;
    n = 0;
    while (bus.switching_out !== lvl && n < limit) begin
      step(1);
      n++;
    end
    check(tag, 32'(bus.switching_out), 32'(lvl));
  endtask

  initial begin
    int  n;
    bit  flag;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.sel_in      = '0;
    bus.prog_r_in   = 16'h4321;
    bus.prog_g_in   = 16'h8765;
    bus.prog_b_in   = 16'hCBA9;
    bus.prog_hs_in  = 4'b0110;
    bus.prog_vs_in  = 4'b1111;
    bus.prog_led_in = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

    // 1: reset held for two edges, then three reset cycles before program 0 runs
    step(2);
    check("rst_prog_rst", 32'(bus.prog_rst_out), 32'hF);
    check("rst_switching", 32'(bus.switching_out), 32'h1);
    check("rst_vga_r", 32'(bus.vga_r_out), 32'h0);
    check("rst_hs", 32'(bus.vga_hs_out), 32'h1);
    check("rst_vs", 32'(bus.vga_vs_out), 32'h1);
    check("rst_led", 32'(bus.led_out), 32'h0);
    check("rst_active", 32'(bus.active_sel_out), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("boot_hold_rst", 32'(bus.prog_rst_out), 32'hF);
      step(1);
    end
    check("boot_run_rst", 32'(bus.prog_rst_out), 32'hE);
    check("boot_run_switching", 32'(bus.switching_out), 32'h0);
    check("boot_run_r", 32'(bus.vga_r_out), 32'h1);
    check("boot_run_g", 32'(bus.vga_g_out), 32'h5);
    check("boot_run_b", 32'(bus.vga_b_out), 32'h9);
    check("boot_run_hs", 32'(bus.vga_hs_out), 32'h0);
    check("boot_run_led", 32'(bus.led_out), 32'hD000);

    // 3: a three-cycle glitch on sel must not be accepted
    bus.sel_in = 2'd1;
    step(3);
    bus.sel_in = 2'd0;
    flag = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      if (bus.switching_out !== 1'b0) flag = 1'b1;
    end
    check("glitch_no_switch", 32'(flag), 32'h0);
    check("glitch_active", 32'(bus.active_sel_out), 32'h0);

    // 2: switch 0 -> 2 at a vsync falling edge of program 0
    bus.sel_in = 2'd2;
    wait_switch("sw2_enter_wait", 1'b1, 20);
    check("sw2_wait_active", 32'(bus.active_sel_out), 32'h0);
    check("sw2_wait_rst", 32'(bus.prog_rst_out), 32'hE);
    check("sw2_wait_r", 32'(bus.vga_r_out), 32'h1);
    step(9);
    check("sw2_still_wait", 32'(bus.switching_out), 32'h1);
    bus.prog_vs_in[0] = 1'b0;
    step(1);
    bus.prog_vs_in[0] = 1'b1;
    check("sw2_hold_active", 32'(bus.active_sel_out), 32'h2);
    check("sw2_hold_r", 32'(bus.vga_r_out), 32'h0);
    check("sw2_hold_led", 32'(bus.led_out), 32'h0);
    check("sw2_hold_vs", 32'(bus.vga_vs_out), 32'h1);
    for (int k = 0; k < 3; k++) begin
      check("sw2_hold_rst", 32'(bus.prog_rst_out), 32'hF);
      step(1);
    end
    check("sw2_run_rst", 32'(bus.prog_rst_out), 32'hB);
    check("sw2_run_switching", 32'(bus.switching_out), 32'h0);
    check("sw2_run_r", 32'(bus.vga_r_out), 32'h3);
    check("sw2_run_g", 32'(bus.vga_g_out), 32'h7);
    check("sw2_run_led", 32'(bus.led_out), 32'hD002);
    step(1);
    check("sw2_run_r_next", 32'(bus.vga_r_out), 32'h3);

    // 4: no vsync edge on the active program -> forced switch after 64 waiting cycles
    bus.sel_in = 2'd3;
    wait_switch("to_enter_wait", 1'b1, 20);
    n = 0;
    while (bus.prog_rst_out !== 4'hF && n < 100) begin
      step(1);
      n++;
    end
    check("to_wait_cycles", 32'(n), 32'd64);
    check("to_hold_active", 32'(bus.active_sel_out), 32'h3);
    step(3);
    check("to_run_rst", 32'(bus.prog_rst_out), 32'h7);
    check("to_run_r", 32'(bus.vga_r_out), 32'h4);
    check("to_run_hs", 32'(bus.vga_hs_out), 32'h0);

    // 5a: request away then back to the running program -> cancel without any reset pulse
    bus.sel_in = 2'd0;
    wait_switch("cancel_enter_wait", 1'b1, 20);
    bus.sel_in = 2'd3;
    flag = 1'b0;
    n = 0;
    while (bus.switching_out !== 1'b0 && n < 30) begin
      step(1);
      n++;
      if (bus.prog_rst_out !== 4'h7) flag = 1'b1;
    end
    check("cancel_back_run", 32'(bus.switching_out), 32'h0);
    check("cancel_no_reset", 32'(flag), 32'h0);
    check("cancel_active", 32'(bus.active_sel_out), 32'h3);

    // 5b: retarget 1 -> 0 while waiting; the last accepted target is used
    bus.sel_in = 2'd1;
    wait_switch("retgt_enter_wait", 1'b1, 20);
    bus.sel_in = 2'd0;
    step(10);
    check("retgt_still_wait", 32'(bus.switching_out), 32'h1);
    check("retgt_wait_active", 32'(bus.active_sel_out), 32'h3);
    bus.prog_vs_in[3] = 1'b0;
    step(1);
    bus.prog_vs_in[3] = 1'b1;
    check("retgt_hold_active", 32'(bus.active_sel_out), 32'h0);
    check("retgt_hold_rst", 32'(bus.prog_rst_out), 32'hF);
    step(3);
    check("retgt_run_rst", 32'(bus.prog_rst_out), 32'hE);
    check("retgt_run_r", 32'(bus.vga_r_out), 32'h1);

    // 6: reset while holding target 2 in reset -> back to program 0
    bus.sel_in = 2'd2;
    wait_switch("midrst_enter_wait", 1'b1, 20);
    bus.prog_vs_in[0] = 1'b0;
    step(1);
    bus.prog_vs_in[0] = 1'b1;
    check("midrst_hold_active", 32'(bus.active_sel_out), 32'h2);
    rst = 1'b1;
    bus.sel_in = 2'd0;
    step(1);
    check("midrst_rst_all", 32'(bus.prog_rst_out), 32'hF);
    check("midrst_rst_active", 32'(bus.active_sel_out), 32'h0);
    step(1);
    rst = 1'b0;
    step(2);
    check("midrst_boot_hold", 32'(bus.prog_rst_out), 32'hF);
    step(1);
    check("midrst_run_rst", 32'(bus.prog_rst_out), 32'hE);
    check("midrst_run_switching", 32'(bus.switching_out), 32'h0);
    check("midrst_run_r", 32'(bus.vga_r_out), 32'h1);
    step(20);
    check("midrst_stays_prog0", 32'(bus.active_sel_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
